id_issue_stage: RTL and testbench

//  Parametrised ARM decode/issue stage: decodes instruction, reads register file, and issues into a

---
 rtl/id_issue_stage_if.sv | 37 +++
 rtl/id_issue_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_id_issue_stage.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/id_issue_stage_if.sv
// ID->EXE issue pipe: ready/valid handshake plus the registered decode and operand fields.
// The issue stage drives through the master modport; the EXE stage consumes through slave.
interface id_issue_stage_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RW   = 4
);
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_rn_val;
    logic [XLEN-1:0] out_rm_val;
    logic [23:0]     out_imm24;
    logic [11:0]     out_shift_op;
    logic [3:0]      out_exe_cmd;
    logic [RW-1:0]   out_dest;
    logic [3:0]      out_status;
    logic            out_wb_en;
    logic            out_mem_r;
    logic            out_mem_w;
    logic            out_s;
    logic            out_b;
    logic            out_imm;

    modport master (
        output out_valid, out_pc, out_rn_val, out_rm_val, out_imm24, out_shift_op,
               out_exe_cmd, out_dest, out_status, out_wb_en, out_mem_r, out_mem_w,
               out_s, out_b, out_imm,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_pc, out_rn_val, out_rm_val, out_imm24, out_shift_op,
               out_exe_cmd, out_dest, out_status, out_wb_en, out_mem_r, out_mem_w,
               out_s, out_b, out_imm,
        output out_ready
    );
endinterface

// File: rtl/id_issue_stage.sv
// ARM decode/issue stage: decode, condition check, bypassed register read, pending-write
// scoreboard for RAW hazards, and a ready/valid pipe register towards EXE.
module id_issue_stage #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned NREGS        = 16,
    parameter int unsigned MAX_INFLIGHT = 3,
    localparam int unsigned RW          = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    input  logic [XLEN-1:0]   pc,
    input  logic [3:0]        status,
    input  logic              wb_en,
    input  logic [RW-1:0]     wb_dest,
    input  logic [XLEN-1:0]   wb_val,
    id_issue_stage_if.master  out_if
);
    localparam int unsigned CntW = $clog2(MAX_INFLIGHT + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rn_val;
        logic [XLEN-1:0] rm_val;
        logic [23:0]     imm24;
        logic [11:0]     shift_op;
        logic [3:0]      exe_cmd;
        logic [RW-1:0]   dest;
        logic [3:0]      status;
        logic            wb_en;
        logic            mem_r;
        logic            mem_w;
        logic            s;
        logic            b;
        logic            imm;
    } pipe_t;

    pipe_t            pipe_q, pipe_d, issue;
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  rf_q [NREGS];
    logic [CntW-1:0]  cnt_q [NREGS];
    logic [CntW-1:0]  cnt_d [NREGS];
    logic [NREGS-1:0] busy, inc_vec, dec_vec;

    logic [3:0]    cond, opcode;
    logic [1:0]    mode;
    logic          s_bit, imm_bit;
    logic [RW-1:0] src1, src2, rd;
    logic          cond_pass, two_src, stall, space, accept, inc_en;
    logic [3:0]    exe_cmd;
    logic          ctl_wb_en, ctl_mem_r, ctl_mem_w, ctl_s, ctl_b;
    logic          n_f, z_f, c_f, v_f;

    assign cond    = instruction[31:28];
    assign mode    = instruction[27:26];
    assign imm_bit = instruction[25];
    assign opcode  = instruction[24:21];
    assign s_bit   = instruction[20];
    assign src1    = RW'(instruction[19:16]);
    assign rd      = RW'(instruction[15:12]);
    assign {n_f, z_f, c_f, v_f} = status;

    always_comb begin
        case (cond)
            4'h0:    cond_pass = z_f;
            4'h1:    cond_pass = !z_f;
            4'h2:    cond_pass = c_f;
            4'h3:    cond_pass = !c_f;
            4'h4:    cond_pass = n_f;
            4'h5:    cond_pass = !n_f;
            4'h6:    cond_pass = v_f;
            4'h7:    cond_pass = !v_f;
            4'h8:    cond_pass = c_f && !z_f;
            4'h9:    cond_pass = !c_f || z_f;
            4'ha:    cond_pass = (n_f == v_f);
            4'hb:    cond_pass = (n_f != v_f);
            4'hc:    cond_pass = !z_f && (n_f == v_f);
            4'hd:    cond_pass = z_f || (n_f != v_f);
            4'he:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        exe_cmd   = 4'b0000;
        ctl_wb_en = 1'b0;
        ctl_mem_r = 1'b0;
        ctl_mem_w = 1'b0;
        ctl_s     = 1'b0;
        ctl_b     = 1'b0;
        case (mode)
            2'b00: begin
                ctl_s = s_bit;
                case (opcode)
                    4'b1101: begin exe_cmd = 4'b0001; ctl_wb_en = 1'b1; end  // MOV
                    4'b1111: begin exe_cmd = 4'b1001; ctl_wb_en = 1'b1; end  // MVN
                    4'b0100: begin exe_cmd = 4'b0010; ctl_wb_en = 1'b1; end  // ADD
                    4'b0101: begin exe_cmd = 4'b0011; ctl_wb_en = 1'b1; end  // ADC
                    4'b0010: begin exe_cmd = 4'b0100; ctl_wb_en = 1'b1; end  // SUB
                    4'b0110: begin exe_cmd = 4'b0101; ctl_wb_en = 1'b1; end  // SBC
                    4'b0000: begin exe_cmd = 4'b0110; ctl_wb_en = 1'b1; end  // AND
                    4'b1100: begin exe_cmd = 4'b0111; ctl_wb_en = 1'b1; end  // ORR
                    4'b0001: begin exe_cmd = 4'b1000; ctl_wb_en = 1'b1; end  // EOR
                    4'b1010: exe_cmd = 4'b0100;                              // CMP
                    4'b1000: exe_cmd = 4'b0110;                              // TST
                    default: ;
                endcase
            end
            2'b01: begin
                exe_cmd = 4'b0010;
                if (s_bit) begin
                    ctl_mem_r = 1'b1;
                    ctl_wb_en = 1'b1;
                end else begin
                    ctl_mem_w = 1'b1;
                end
            end
            2'b10:   ctl_b = 1'b1;
            default: ;
        endcase
    end

    assign src2    = ctl_mem_w ? rd : RW'(instruction[3:0]);
    assign two_src = !imm_bit || ctl_mem_w;

    // A register is busy while a writer sits in the pipe register or has more unretired
    // writers than the WB retiring this very cycle (that one is covered by the bypass).
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            dec_vec[r] = wb_en && (wb_dest == RW'(r));
            busy[r]    = (valid_q && pipe_q.wb_en && (pipe_q.dest == RW'(r))) ||
                         (cnt_q[r] > (dec_vec[r] ? CntW'(1) : CntW'(0)));
        end
    end

    assign stall    = in_valid && cond_pass && ((!ctl_b && busy[src1]) ||
                                                (two_src && busy[src2]));
    assign space    = !valid_q || out_if.out_ready;
    assign in_ready = flush || (space && !stall);
    assign accept   = in_valid && in_ready && !flush;
    assign inc_en   = valid_q && out_if.out_ready && pipe_q.wb_en && !flush;

    always_comb begin
        issue.pc       = pc;
        issue.rn_val   = (wb_en && wb_dest == src1) ? wb_val : rf_q[src1];
        issue.rm_val   = (wb_en && wb_dest == src2) ? wb_val : rf_q[src2];
        issue.imm24    = instruction[23:0];
        issue.shift_op = instruction[11:0];
        issue.exe_cmd  = exe_cmd;
        issue.dest     = rd;
        issue.status   = status;
        issue.wb_en    = ctl_wb_en;
        issue.mem_r    = ctl_mem_r;
        issue.mem_w    = ctl_mem_w;
        issue.s        = ctl_s;
        issue.b        = ctl_b;
        issue.imm      = imm_bit;
    end

    always_comb begin
        pipe_d  = pipe_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept && cond_pass) begin
            valid_d = 1'b1;
            pipe_d  = issue;
        end else if (out_if.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            inc_vec[r] = inc_en && (pipe_q.dest == RW'(r));
            cnt_d[r]   = cnt_q[r];
            if (inc_vec[r] && !dec_vec[r]) begin
                cnt_d[r] = cnt_q[r] + CntW'(1);
            end else if (dec_vec[r] && !inc_vec[r]) begin
                cnt_d[r] = cnt_q[r] - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            pipe_q  <= '0;
            for (int r = 0; r < NREGS; r++) begin
                rf_q[r]  <= '0;
                cnt_q[r] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            pipe_q  <= pipe_d;
            for (int r = 0; r < NREGS; r++) begin
                assert (!(inc_vec[r] && !dec_vec[r] && cnt_q[r] == CntW'(MAX_INFLIGHT)));
                assert (!(dec_vec[r] && !inc_vec[r] && cnt_q[r] == '0));
                cnt_q[r] <= cnt_d[r];
            end
            if (wb_en) begin
                rf_q[wb_dest] <= wb_val;
            end
        end
    end

    assign out_if.out_valid    = valid_q;
    assign out_if.out_pc       = pipe_q.pc;
    assign out_if.out_rn_val   = pipe_q.rn_val;
    assign out_if.out_rm_val   = pipe_q.rm_val;
    assign out_if.out_imm24    = pipe_q.imm24;
    assign out_if.out_shift_op = pipe_q.shift_op;
    assign out_if.out_exe_cmd  = pipe_q.exe_cmd;
    assign out_if.out_dest     = pipe_q.dest;
    assign out_if.out_status   = pipe_q.status;
    assign out_if.out_wb_en    = pipe_q.wb_en;
    assign out_if.out_mem_r    = pipe_q.mem_r;
    assign out_if.out_mem_w    = pipe_q.mem_w;
    assign out_if.out_s        = pipe_q.s;
    assign out_if.out_b        = pipe_q.b;
    assign out_if.out_imm      = pipe_q.imm;
endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage: reset, RAW stall with WB bypass, double writer,
// backpressure, flush and failed-condition drop, each checked by immediate assertion.
module tb_id_issue_stage;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 16;
    localparam int unsigned RW    = 4;

    localparam logic [31:0] AddR1R2R3 = 32'hE082_1003;
    localparam logic [31:0] AddR4R1R5 = 32'hE081_4005;
    localparam logic [31:0] MovR1Imm5 = 32'hE3A0_1005;
    localparam logic [31:0] AddR7R1R1 = 32'hE081_7001;
    localparam logic [31:0] MovR8Imm  = 32'hE3A0_8044;
    localparam logic [31:0] MoveqR6   = 32'h03A0_6001;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic [XLEN-1:0] pc;
    logic [3:0]      status;
    logic            wb_en;
    logic [RW-1:0]   wb_dest;
    logic [XLEN-1:0] wb_val;

    int errors = 0;
    int checks = 0;

    id_issue_stage_if #(.XLEN(XLEN), .RW(RW)) pipe_if ();

    id_issue_stage #(.XLEN(XLEN), .NREGS(NREGS), .MAX_INFLIGHT(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .pc          (pc),
        .status      (status),
        .wb_en       (wb_en),
        .wb_dest     (wb_dest),
        .wb_val      (wb_val),
        .out_if      (pipe_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] cnt(input int r);
        return 64'(dut.cnt_q[r]);
    endfunction

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b1; instruction = AddR1R2R3; pc = 32'h10;
        status = 4'h0; wb_en = 1'b0; wb_dest = '0; wb_val = '0; pipe_if.out_ready = 1'b1;
        tick();
        tick();
        chk("reset_valid", 64'(pipe_if.out_valid), 64'd0);
        chk("reset_pc", 64'(pipe_if.out_pc), 64'd0);
        chk("reset_cmd", 64'(pipe_if.out_exe_cmd), 64'd0);
        chk("reset_dest", 64'(pipe_if.out_dest), 64'd0);
        chk("reset_wb_en", 64'(pipe_if.out_wb_en), 64'd0);
        chk("reset_cnt1", cnt(1), 64'd0);
        rst = 1'b1;
        #1 chk("release_ready", 64'(in_ready), 64'd1);

        // ADD R1 issues, dependent ADD R4 stalls until R1 retires
        tick();
        chk("issue_valid", 64'(pipe_if.out_valid), 64'd1);
        chk("issue_dest", 64'(pipe_if.out_dest), 64'd1);
        chk("issue_cmd", 64'(pipe_if.out_exe_cmd), 64'd2);
        chk("issue_pc", 64'(pipe_if.out_pc), 64'h10);
        chk("issue_wb_en", 64'(pipe_if.out_wb_en), 64'd1);
        instruction = AddR4R1R5; pc = 32'h14;
        #1 chk("raw_stall_pipe", 64'(in_ready), 64'd0);
        tick();
        chk("raw_cnt1", cnt(1), 64'd1);
        chk("raw_drain_valid", 64'(pipe_if.out_valid), 64'd0);
        chk("raw_stall_cnt", 64'(in_ready), 64'd0);
        wb_en = 1'b1; wb_dest = 4'd1; wb_val = 32'h1234;
        #1 chk("raw_wb_release", 64'(in_ready), 64'd1);
        tick();
        chk("bypass_valid", 64'(pipe_if.out_valid), 64'd1);
        chk("bypass_rn", 64'(pipe_if.out_rn_val), 64'h1234);
        chk("bypass_dest", 64'(pipe_if.out_dest), 64'd4);
        chk("raw_cnt1_retired", cnt(1), 64'd0);

        // Two writers of R1 in flight; reader waits for the second WB
        wb_en = 1'b0; instruction = AddR1R2R3; pc = 32'h18;
        tick();
        instruction = MovR1Imm5; pc = 32'h1c;
        tick();
        in_valid = 1'b0;
        tick();
        chk("waw_cnt2", cnt(1), 64'd2);
        chk("waw_cnt4", cnt(4), 64'd1);
        in_valid = 1'b1; instruction = AddR7R1R1; pc = 32'h100;
        wb_en = 1'b1; wb_dest = 4'd1; wb_val = 32'hAAAA;
        #1 chk("waw_first_wb", 64'(in_ready), 64'd0);
        tick();
        chk("waw_cnt1_after_first", cnt(1), 64'd1);
        wb_val = 32'hBBBB;
        #1 chk("waw_second_wb", 64'(in_ready), 64'd1);
        tick();
        chk("waw_rn", 64'(pipe_if.out_rn_val), 64'hBBBB);
        chk("waw_rm", 64'(pipe_if.out_rm_val), 64'hBBBB);
        chk("waw_cnt1_done", cnt(1), 64'd0);

        // Backpressure: pipe register held for three cycles
        wb_en = 1'b0; pipe_if.out_ready = 1'b0; instruction = MovR8Imm; pc = 32'h104;
        #1 chk("bp_ready_now", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", 64'(pipe_if.out_valid), 64'd1);
            chk("bp_dest", 64'(pipe_if.out_dest), 64'd7);
            chk("bp_pc", 64'(pipe_if.out_pc), 64'h100);
            chk("bp_rn", 64'(pipe_if.out_rn_val), 64'hBBBB);
            chk("bp_ready", 64'(in_ready), 64'd0);
            chk("bp_cnt7", cnt(7), 64'd0);
        end
        pipe_if.out_ready = 1'b1;
        #1 chk("bp_release", 64'(in_ready), 64'd1);
        tick();
        chk("mov_dest", 64'(pipe_if.out_dest), 64'd8);
        chk("mov_cmd", 64'(pipe_if.out_exe_cmd), 64'd1);
        chk("mov_shift", 64'(pipe_if.out_shift_op), 64'h044);
        chk("mov_imm", 64'(pipe_if.out_imm), 64'd1);
        chk("mov_pc", 64'(pipe_if.out_pc), 64'h104);
        chk("mov_cnt7", cnt(7), 64'd1);

        // Flush squashes the pipe register; WB of R7 still retires
        flush = 1'b1; wb_en = 1'b1; wb_dest = 4'd7; wb_val = 32'h77;
        instruction = AddR1R2R3; pc = 32'h108;
        #1 chk("flush_ready", 64'(in_ready), 64'd1);
        tick();
        chk("flush_valid", 64'(pipe_if.out_valid), 64'd0);
        chk("flush_cnt8", cnt(8), 64'd0);
        chk("flush_cnt7", cnt(7), 64'd0);
        chk("flush_cnt1", cnt(1), 64'd0);

        // MOVEQ with Z=0 is consumed and dropped; with Z=1 it issues
        flush = 1'b0; wb_en = 1'b0; status = 4'b0000; instruction = MoveqR6; pc = 32'h10c;
        #1 chk("condfail_ready", 64'(in_ready), 64'd1);
        tick();
        chk("condfail_valid", 64'(pipe_if.out_valid), 64'd0);
        chk("condfail_cnt6", cnt(6), 64'd0);
        status = 4'b0100;
        tick();
        chk("condpass_valid", 64'(pipe_if.out_valid), 64'd1);
        chk("condpass_dest", 64'(pipe_if.out_dest), 64'd6);
        chk("condpass_status", 64'(pipe_if.out_status), 64'h4);

        // Reset mid-operation clears pipe and scoreboard
        rst = 1'b0;
        tick();
        chk("midreset_valid", 64'(pipe_if.out_valid), 64'd0);
        chk("midreset_dest", 64'(pipe_if.out_dest), 64'd0);
        chk("midreset_status", 64'(pipe_if.out_status), 64'd0);
        chk("midreset_cnt4", cnt(4), 64'd0);
        chk("midreset_cnt6", cnt(6), 64'd0);
        rst = 1'b1; in_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
